// File: rtl/sonar_pkg.sv
// Shared types and constants for the HC-SR04 ranger: FSM state encoding,
// default 100 MHz timing and distance saturation helper.
package sonar_pkg;

    typedef enum logic [1:0] {
        ST_HOLDOFF   = 2'd0,
        ST_TRIG      = 2'd1,
        ST_WAIT_RISE = 2'd2,
        ST_MEASURE   = 2'd3
    } state_e;

    // Defaults for the 100 MHz Basys3 clock.
    localparam int unsigned DEF_TRIG_CYCLES    = 1000;
    localparam int unsigned DEF_UNIT_CYCLES    = 58;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 3000000;
    localparam int unsigned DEF_PERIOD_CYCLES  = 6000000;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned DIST_W      = 20;
    localparam logic [DIST_W-1:0] DIST_MAX = 20'hFFFFF;

    function automatic logic [DIST_W-1:0] sat_inc(input logic [DIST_W-1:0] v);
        logic [DIST_W-1:0] r;
        r = (v == DIST_MAX) ? v : v + 20'd1;
        return r;
    endfunction

endpackage

// File: rtl/sonar_ranger_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input followed by a registered
// previous value; rise/fall are single-cycle pulses with equal latency.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_d[gi] = async_in;
            end else begin : g_next
                assign sync_d[gi] = sync_q[gi-1];
            end
        end
    endgenerate

    always_comb begin
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[STAGES-1] & ~prev_q;
    assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/sonar_ranger.sv
// HC-SR04 driver: periodic trigger, echo width timing and conversion to
// 0.01 cm units by prescaled counting (no divider).
module sonar_ranger
    import sonar_pkg::*;
#(
    parameter int unsigned TRIG_CYCLES    = DEF_TRIG_CYCLES,
    parameter int unsigned UNIT_CYCLES    = DEF_UNIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned PERIOD_CYCLES  = DEF_PERIOD_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        echo,
    output logic        trig,
    output logic [19:0] distance,
    output logic        valid,
    output logic        timeout
);

    localparam int unsigned CYC_W = $clog2(PERIOD_CYCLES);
    localparam int unsigned PRE_W = $clog2(UNIT_CYCLES);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(PERIOD_CYCLES - 1);
    localparam logic [CYC_W-1:0] TRIG_LAST = CYC_W'(TRIG_CYCLES - 1);
    localparam logic [CYC_W-1:0] TO_LAST   = CYC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(UNIT_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [DIST_W-1:0]  acc_q, acc_d;
    logic [DIST_W-1:0]  distance_q, distance_d;
    logic               trig_q, trig_d;
    logic               valid_q, valid_d;
    logic               timeout_q, timeout_d;
    logic [DIST_W-1:0]  acc_inc;
    logic               echo_rise;
    logic               echo_fall;

    sync_edge #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (echo),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q + CYC_W'(1);
        pre_d      = pre_q;
        acc_d      = acc_q;
        distance_d = distance_q;
        trig_d     = 1'b0;
        valid_d    = 1'b0;
        timeout_d  = timeout_q;
        // Count including this cycle, so a falling edge captures floor(N/UNIT).
        acc_inc    = (pre_q == PRE_LAST) ? sat_inc(acc_q) : acc_q;

        unique case (state_q)
            ST_HOLDOFF: begin
                if (cyc_q == CYC_LAST) begin
                    state_d = ST_TRIG;
                    cyc_d   = '0;
                    trig_d  = 1'b1;
                end
            end
            ST_TRIG: begin
                if (cyc_q == TRIG_LAST) begin
                    state_d = ST_WAIT_RISE;
                end else begin
                    trig_d = 1'b1;
                end
            end
            ST_WAIT_RISE: begin
                // Timeout wins a tie so MEASURE never starts past its deadline.
                if (cyc_q == TO_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end else if (echo_rise) begin
                    state_d = ST_MEASURE;
                    pre_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_MEASURE: begin
                pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
                acc_d = acc_inc;
                if (echo_fall) begin
                    state_d    = ST_HOLDOFF;
                    distance_d = acc_inc;
                    timeout_d  = 1'b0;
                    valid_d    = 1'b1;
                end else if (cyc_q == TO_LAST) begin
                    state_d   = ST_HOLDOFF;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                end
            end
            default: begin
                state_d = ST_HOLDOFF;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HOLDOFF;
            cyc_q      <= CYC_LAST;
            pre_q      <= '0;
            acc_q      <= '0;
            distance_q <= '0;
            trig_q     <= 1'b0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            pre_q      <= pre_d;
            acc_q      <= acc_d;
            distance_q <= distance_d;
            trig_q     <= trig_d;
            valid_q    <= valid_d;
            timeout_q  <= timeout_d;
        end
    end

    assign trig     = trig_q;
    assign distance = distance_q;
    assign valid    = valid_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_sonar_ranger.sv
// Directed bench for sonar_ranger with short timing parameters
// (TRIG=4, UNIT=5, TIMEOUT=200, PERIOD=300).
module tb_sonar_ranger;

    logic        clk = 1'b0;
    logic        reset;
    logic        echo;
    logic        trig;
    logic [19:0] distance;
    logic        valid;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sonar_ranger #(
        .TRIG_CYCLES    (4),
        .UNIT_CYCLES    (5),
        .TIMEOUT_CYCLES (200),
        .PERIOD_CYCLES  (300)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .echo     (echo),
        .trig     (trig),
        .distance (distance),
        .valid    (valid),
        .timeout  (timeout)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts just after the edge where trig rose (t=0); runs to t=295.
    task automatic run_period(input int rise_at, input int width,
                              output int n_valid, output int valid_at,
                              output logic [19:0] dist_seen, output logic to_seen,
                              output int glitches);
        logic [19:0] prev_dist;
        n_valid   = 0;
        valid_at  = -1;
        dist_seen = '0;
        to_seen   = 1'b0;
        glitches  = 0;
        prev_dist = distance;
        for (int t = 1; t <= 295; t++) begin
            tick();
            if (valid === 1'b1) begin
                n_valid++;
                valid_at  = t;
                dist_seen = distance;
                to_seen   = timeout;
            end else if (distance !== prev_dist) begin
                glitches++;
            end
            prev_dist = distance;
            if (rise_at > 0 && t == rise_at) echo = 1'b1;
            if (width > 0 && t == rise_at + width) echo = 1'b0;
        end
        $display("period rise_at=%0d width=%0d valids=%0d valid_at=%0d distance=%0d timeout=%0b",
                 rise_at, width, n_valid, valid_at, dist_seen, to_seen);
    endtask

    // Called just after t=295; the next trigger is due 5 edges later.
    task automatic wait_trig();
        int steps;
        steps = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (trig === 1'b1) begin
                steps = k;
                break;
            end
        end
        n_checks++;
        if (steps != 5) begin
            n_fail++;
            $display("FAIL next_trigger: trig rose after %0d cycles, required 5", steps);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        echo  = 1'b0;
        repeat (3) tick();
        $display("reset: trig=%0b valid=%0b distance=%0d timeout=%0b", trig, valid, distance, timeout);
        n_checks++;
        if (trig !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %0b required 0", trig); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b required 0", valid); end
        n_checks++;
        if (distance !== 20'd0) begin n_fail++; $display("FAIL reset_distance: got %0d required 0", distance); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %0b required 0", timeout); end
    endtask

    task automatic test_trigger_and_timeout();
        int          trig_bad;
        int          nv;
        int          va;
        logic [19:0] d;
        logic        to;
        logic        exp_trig;
        trig_bad = 0;
        nv = 0;
        va = -1;
        d  = '0;
        to = 1'b0;
        reset = 1'b0;
        tick();
        n_checks++;
        if (trig !== 1'b1) begin n_fail++; $display("FAIL first_trig: got %0b required 1", trig); end
        for (int t = 1; t <= 300; t++) begin
            tick();
            exp_trig = (t < 4) || (t == 300);
            if (trig !== exp_trig) trig_bad++;
            if (t < 300 && valid === 1'b1) begin
                nv++;
                va = t;
                d  = distance;
                to = timeout;
            end
        end
        $display("no-echo period: trig_errors=%0d valids=%0d valid_at=%0d distance=%0d timeout=%0b",
                 trig_bad, nv, va, d, to);
        n_checks++;
        if (trig_bad != 0) begin n_fail++; $display("FAIL trig_waveform: %0d wrong cycles, required 0", trig_bad); end
        n_checks++;
        if (nv != 1) begin n_fail++; $display("FAIL noecho_valid_count: got %0d required 1", nv); end
        n_checks++;
        if (va != 200) begin n_fail++; $display("FAIL noecho_valid_cycle: got %0d required 200", va); end
        n_checks++;
        if (to !== 1'b1) begin n_fail++; $display("FAIL noecho_timeout: got %0b required 1", to); end
        n_checks++;
        if (d !== 20'd0) begin n_fail++; $display("FAIL noecho_distance: got %0d required 0", d); end
    endtask

    task automatic test_measure(input int width, input logic [19:0] exp_dist);
        int          nv;
        int          va;
        int          gl;
        logic [19:0] d;
        logic        to;
        run_period(24, width, nv, va, d, to, gl);
        n_checks++;
        if (nv != 1) begin n_fail++; $display("FAIL measure_w%0d_valid_count: got %0d required 1", width, nv); end
        n_checks++;
        if (va != 24 + width + 3) begin
            n_fail++;
            $display("FAIL measure_w%0d_valid_cycle: got %0d required %0d", width, va, 24 + width + 3);
        end
        n_checks++;
        if (d !== exp_dist) begin n_fail++; $display("FAIL measure_w%0d_distance: got %0d required %0d", width, d, exp_dist); end
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL measure_w%0d_timeout: got %0b required 0", width, to); end
        n_checks++;
        if (gl != 0) begin n_fail++; $display("FAIL measure_w%0d_stable: %0d distance changes without valid, required 0", width, gl); end
        wait_trig();
    endtask

    task automatic test_floor_boundary();
        test_measure(55, 20'd11);
        test_measure(54, 20'd10);
    endtask

    task automatic test_stuck_high();
        int          nv;
        int          va;
        int          gl;
        logic [19:0] d;
        logic        to;
        test_measure_lead_in();
        run_period(0, 0, nv, va, d, to, gl);
        n_checks++;
        if (nv != 1) begin n_fail++; $display("FAIL stuck_valid_count: got %0d required 1", nv); end
        n_checks++;
        if (va != 200) begin n_fail++; $display("FAIL stuck_valid_cycle: got %0d required 200", va); end
        n_checks++;
        if (to !== 1'b1) begin n_fail++; $display("FAIL stuck_timeout: got %0b required 1", to); end
        n_checks++;
        if (d !== 20'd11) begin n_fail++; $display("FAIL stuck_distance: got %0d required 11", d); end
        echo = 1'b0;
        wait_trig();
    endtask

    // Measures 55 clocks (distance 11), then raises echo in HOLDOFF so it is
    // already high when the next trigger fires.
    task automatic test_measure_lead_in();
        int          nv;
        int          va;
        int          gl;
        logic [19:0] d;
        logic        to;
        run_period(24, 55, nv, va, d, to, gl);
        n_checks++;
        if (d !== 20'd11 || nv != 1) begin
            n_fail++;
            $display("FAIL leadin_distance: got %0d (valids %0d) required 11 (valids 1)", d, nv);
        end
        echo = 1'b1;
        wait_trig();
    endtask

    task automatic test_echo_timeout();
        int          nv;
        int          va;
        int          gl;
        logic [19:0] d;
        logic        to;
        run_period(24, 226, nv, va, d, to, gl);
        n_checks++;
        if (nv != 1) begin n_fail++; $display("FAIL long_echo_valid_count: got %0d required 1", nv); end
        n_checks++;
        if (va != 200) begin n_fail++; $display("FAIL long_echo_valid_cycle: got %0d required 200", va); end
        n_checks++;
        if (to !== 1'b1) begin n_fail++; $display("FAIL long_echo_timeout: got %0b required 1", to); end
        n_checks++;
        if (d !== 20'd11) begin n_fail++; $display("FAIL long_echo_distance: got %0d required 11", d); end
        wait_trig();
        test_measure(50, 20'd10);
    endtask

    task automatic test_reset_mid_measure();
        int          nv;
        int          va;
        int          gl;
        logic [19:0] d;
        logic        to;
        for (int t = 1; t <= 54; t++) begin
            tick();
            if (t == 24) echo = 1'b1;
        end
        reset = 1'b1;
        echo  = 1'b0;
        tick();
        $display("mid-measure reset: trig=%0b valid=%0b distance=%0d timeout=%0b", trig, valid, distance, timeout);
        n_checks++;
        if (trig !== 1'b0) begin n_fail++; $display("FAIL midreset_trig: got %0b required 0", trig); end
        n_checks++;
        if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %0b required 0", valid); end
        n_checks++;
        if (distance !== 20'd0) begin n_fail++; $display("FAIL midreset_distance: got %0d required 0", distance); end
        n_checks++;
        if (timeout !== 1'b0) begin n_fail++; $display("FAIL midreset_timeout: got %0b required 0", timeout); end
        reset = 1'b0;
        tick();
        n_checks++;
        if (trig !== 1'b1) begin n_fail++; $display("FAIL midreset_retrigger: got %0b required 1", trig); end
        run_period(24, 50, nv, va, d, to, gl);
        n_checks++;
        if (d !== 20'd10 || nv != 1) begin
            n_fail++;
            $display("FAIL midreset_measure: got distance %0d (valids %0d) required 10 (valids 1)", d, nv);
        end
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL midreset_measure_timeout: got %0b required 0", to); end
    endtask

    initial begin
        reset = 1'b1;
        echo  = 1'b0;
        test_reset();
        test_trigger_and_timeout();
        test_measure(50, 20'd10);
        test_floor_boundary();
        test_stuck_high();
        test_echo_timeout();
        test_reset_mid_measure();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
